mp_ram_ctrl: RTL and testbench

- Parametrised N-port RAM controller; successor to the two-port valid/ready RAM interface.
- Each port has one request channel (address, write enable, data, byte strobes) and one read-response channel, both with valid/ready handshakes.
- Adds the following over the two-port generation:
  - configurable port count, data width and depth
  - byte-strobed writes
  - deterministic write-collision arbitration
  - out-of-range error reporting
  - per-port response back-pressure
- Sits between verification/bus agents and the behavioural storage array in the RAM subsystem.

---
 rtl/mp_ram_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mp_ram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// mp_ram_ctrl -- N-port RAM controller with valid/ready request and response
// channels per port, byte-strobed writes, fixed-priority write-collision
// arbitration and out-of-range error reporting.
//
// Ports (p = port index, slices at [p*W +: W]):
//   aclk, aresetn          clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready    request handshake per port
//   req_we                 1 = write, 0 = read
//   req_addr               word address per port (ADDR_WIDTH bits)
//   req_wdata/req_wstrb    write data and byte enables (bit b -> bits [8b+7:8b])
//   rsp_valid/rsp_ready    read-response handshake per port
//   rsp_rdata/rsp_err      read data and out-of-range flag
//   wr_err                 one-cycle pulse after an out-of-range write is dropped
//
// Pipeline: stage p0 decodes requests combinationally and issues array
// accesses; stage p1 is the per-port one-entry response register.
// ---------------------------------------------------------------------------
module mp_ram_ctrl #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int BUS_WIDTH  = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS-1:0]               req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*(BUS_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]               rsp_valid,
  input  logic [NUM_PORTS-1:0]               rsp_ready,
  output logic [NUM_PORTS*BUS_WIDTH-1:0]     rsp_rdata,
  output logic [NUM_PORTS-1:0]               rsp_err,
  output logic [NUM_PORTS-1:0]               wr_err
);

  localparam int NB    = BUS_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  // Unsigned range check with one guard bit so DEPTH == 2**ADDR_WIDTH works.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  // Replace only the strobed bytes of a stored word.
  function automatic logic [BUS_WIDTH-1:0] merge_bytes(
    input logic [BUS_WIDTH-1:0] old_word,
    input logic [BUS_WIDTH-1:0] new_word,
    input logic [NB-1:0]        strb
  );
    logic [BUS_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Storage array; contents are deliberately not reset.
  logic [BUS_WIDTH-1:0] mem [DEPTH];

  // Goes high on the first edge after reset release, so ready stays low
  // for that first cycle.
  logic aresetn_q;

  logic [ADDR_WIDTH-1:0] addr_p0  [NUM_PORTS];
  logic [IDX_W-1:0]      idx_p0   [NUM_PORTS];
  logic [BUS_WIDTH-1:0]  wdata_p0 [NUM_PORTS];
  logic [NB-1:0]         wstrb_p0 [NUM_PORTS];
  logic [BUS_WIDTH-1:0]  rdata_p0 [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_range_p0;
  logic [NUM_PORTS-1:0]  collide_p0;
  logic [NUM_PORTS-1:0]  acc_p0;
  logic [NUM_PORTS-1:0]  wr_en_p0;
  logic [NUM_PORTS-1:0]  rd_acc_p0;

  logic [NUM_PORTS-1:0]  vld_p1;
  logic [BUS_WIDTH-1:0]  rdata_p1 [NUM_PORTS];
  logic [NUM_PORTS-1:0]  err_p1;
  logic [NUM_PORTS-1:0]  wr_err_p1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) aresetn_q <= 1'b0;
    else          aresetn_q <= 1'b1;
  end

  // ---- stage p0: request decode, arbitration, array access ----
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_p0[p]     = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      idx_p0[p]      = addr_p0[p][IDX_W-1:0];
      wdata_p0[p]    = req_wdata[p*BUS_WIDTH +: BUS_WIDTH];
      wstrb_p0[p]    = req_wstrb[p*NB +: NB];
      in_range_p0[p] = addr_in_range(addr_p0[p]);
      // Out-of-range reads return zero rather than indexing past the array.
      rdata_p0[p]    = in_range_p0[p] ? mem[idx_p0[p]] : '0;
    end
  end

  // A port is blocked whenever a lower-index port presents a write to the
  // same address, whether or not that lower port is itself ready; reads on
  // the lower port never block anyone.
  always_comb begin
    collide_p0 = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (req_valid[q] && req_we[q] && req_valid[p] &&
            (addr_p0[q] == addr_p0[p])) begin
          collide_p0[p] = 1'b1;
        end
      end
    end
  end

  // Writes ignore the response channel; reads need the response slot free
  // now or freed at this edge.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = aresetn_q && !collide_p0[p] &&
                     (req_we[p] || !vld_p1[p] || rsp_ready[p]);
    end
  end

  assign acc_p0    = req_valid & req_ready;
  assign wr_en_p0  = acc_p0 & req_we & in_range_p0;
  assign rd_acc_p0 = acc_p0 & ~req_we;

  // Arbitration guarantees accepted writes target distinct addresses, so
  // the per-port updates below never overlap. Reads sample the array
  // before these updates take effect (read-first).
  always_ff @(posedge aclk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en_p0[p]) begin
        mem[idx_p0[p]] <= merge_bytes(mem[idx_p0[p]], wdata_p0[p], wstrb_p0[p]);
      end
    end
  end

  // ---- stage p1: per-port response register and write-error pulse ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1    <= '0;
      err_p1    <= '0;
      wr_err_p1 <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rdata_p1[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_err_p1[p] <= acc_p0[p] && req_we[p] && !in_range_p0[p];
        if (rd_acc_p0[p]) begin
          // A new read overwrites the slot even while it is being consumed,
          // which keeps rsp_valid continuous for back-to-back reads.
          vld_p1[p]   <= 1'b1;
          rdata_p1[p] <= rdata_p0[p];
          err_p1[p]   <= !in_range_p0[p];
        end else if (vld_p1[p] && rsp_ready[p]) begin
          vld_p1[p]   <= 1'b0;
          rdata_p1[p] <= '0;
          err_p1[p]   <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_rdata[p*BUS_WIDTH +: BUS_WIDTH] = rdata_p1[p];
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign wr_err    = wr_err_p1;

endmodule

// File: tb/tb_mp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mp_ram_ctrl -- self-checking bench for mp_ram_ctrl (2 ports, 64-bit,
// DEPTH=1000). Directed table of single-port operations, hand-written
// multi-cycle sequences (collision, read-first, back-pressure, reset with a
// pending response), then randomized traffic checked every cycle against a
// behavioural model (word array + one expected response per port).
// ---------------------------------------------------------------------------
module tb_mp_ram_ctrl;

  localparam int NP = 2;
  localparam int AW = 10;
  localparam int BW = 64;
  localparam int DP = 1000;

  logic              aclk;
  logic              aresetn;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_we;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*BW-1:0]  req_wdata;
  logic [NP*8-1:0]   req_wstrb;
  logic [NP-1:0]     rsp_valid;
  logic [NP-1:0]     rsp_ready;
  logic [NP*BW-1:0]  rsp_rdata;
  logic [NP-1:0]     rsp_err;
  logic [NP-1:0]     wr_err;

  mp_ram_ctrl #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .DEPTH(DP)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wr_err(wr_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Per-port drive values
  logic [NP-1:0] v, we_d, rr;
  logic [AW-1:0] a_d [NP];
  logic [BW-1:0] d_d [NP];
  logic [7:0]    s_d [NP];

  // Values sampled mid-cycle by cycle()
  logic [NP-1:0] s_rdy, s_rvalid, s_err, s_werr;
  logic [BW-1:0] s_rdata [NP];

  // Behavioural model
  logic [BW-1:0] mmem [1024];
  logic [NP-1:0] m_has, m_eerr, m_wpend, m_acc;
  logic [BW-1:0] m_edata [NP];
  logic          m_live;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    v = '0; we_d = '0; rr = '1;
    for (int p = 0; p < NP; p++) begin a_d[p] = '0; d_d[p] = '0; s_d[p] = '0; end
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, checks outputs
  // against the model at posedge+4, advances the model, waits for the edge.
  task automatic cycle();
    logic [NP-1:0] col, erdy, acc;
    logic [BW-1:0] rd [NP];
    logic [BW-1:0] w;
    for (int p = 0; p < NP; p++) begin
      req_valid[p] = v[p];
      req_we[p]    = we_d[p];
      rsp_ready[p] = rr[p];
      req_addr[p*AW +: AW]  = a_d[p];
      req_wdata[p*BW +: BW] = d_d[p];
      req_wstrb[p*8 +: 8]   = s_d[p];
    end
    #3;
    s_rdy = req_ready; s_rvalid = rsp_valid; s_err = rsp_err; s_werr = wr_err;
    for (int p = 0; p < NP; p++) s_rdata[p] = rsp_rdata[p*BW +: BW];
    acc = '0;
    if (!aresetn) begin
      chk("rst_ready", 64'(s_rdy), 64'd0);
      chk("rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_rerr", 64'(s_err), 64'd0);
      chk("rst_wrerr", 64'(s_werr), 64'd0);
      for (int p = 0; p < NP; p++) chk($sformatf("rst_rdata%0d", p), s_rdata[p], 64'd0);
      m_has = '0; m_wpend = '0; m_live = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        col[p] = 1'b0;
        for (int q = 0; q < p; q++)
          if (v[q] && we_d[q] && v[p] && a_d[q] == a_d[p]) col[p] = 1'b1;
        erdy[p] = m_live && !col[p] && (we_d[p] || !m_has[p] || rr[p]);
        chk($sformatf("ready%0d", p), 64'(s_rdy[p]), 64'(erdy[p]));
        chk($sformatf("rvalid%0d", p), 64'(s_rvalid[p]), 64'(m_has[p]));
        if (m_has[p]) begin
          chk($sformatf("rdata%0d", p), s_rdata[p], m_edata[p]);
          chk($sformatf("rerr%0d", p), 64'(s_err[p]), 64'(m_eerr[p]));
        end
        chk($sformatf("wrerr%0d", p), 64'(s_werr[p]), 64'(m_wpend[p]));
      end
      acc = v & erdy;
      // Read data reflects the array before any write at this edge.
      for (int p = 0; p < NP; p++)
        rd[p] = (int'(a_d[p]) < DP) ? mmem[a_d[p]] : 64'd0;
      for (int p = 0; p < NP; p++) begin
        m_wpend[p] = acc[p] && we_d[p] && (int'(a_d[p]) >= DP);
        if (acc[p] && we_d[p] && int'(a_d[p]) < DP) begin
          w = mmem[a_d[p]];
          for (int b = 0; b < 8; b++) if (s_d[p][b]) w[8*b +: 8] = d_d[p][8*b +: 8];
          mmem[a_d[p]] = w;
        end
        if (acc[p] && !we_d[p]) begin
          m_has[p] = 1'b1; m_edata[p] = rd[p]; m_eerr[p] = (int'(a_d[p]) >= DP);
        end else if (m_has[p] && rr[p]) begin
          m_has[p] = 1'b0;
        end
      end
      m_live = 1'b1;
    end
    m_acc = acc;
    @(posedge aclk);
    #1;
  endtask

  // Single-port operation: hold until accepted, then check the outcome.
  task automatic do_op(input int p, input bit w, input logic [AW-1:0] addr,
                       input logic [BW-1:0] data, input logic [7:0] strb,
                       input logic [BW-1:0] exp_d, input bit exp_e, input string name);
    int n;
    idle();
    v[p] = 1'b1; we_d[p] = w; a_d[p] = addr; d_d[p] = data; s_d[p] = strb;
    n = 0;
    do begin cycle(); n++; end while (!m_acc[p] && n < 20);
    chk({name, "_accept"}, 64'(m_acc[p]), 64'd1);
    v[p] = 1'b0;
    cycle();
    if (w) begin
      chk({name, "_wrerr"}, 64'(s_werr[p]), 64'(exp_e));
      cycle();
      chk({name, "_wrerr_end"}, 64'(s_werr[p]), 64'd0);
    end else begin
      chk({name, "_rvalid"}, 64'(s_rvalid[p]), 64'd1);
      chk({name, "_rdata"}, s_rdata[p], exp_d);
      chk({name, "_rerr"}, 64'(s_err[p]), 64'(exp_e));
    end
  endtask

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [7:0]    strb;
    logic [BW-1:0] exp_d;
    bit            exp_e;
  } vec_t;

  vec_t tbl [10];
  logic [AW-1:0] pool [7];
  logic [NP-1:0] pend;

  initial begin
    tbl[0] = '{0, 1, 10'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'd0, 0};
    tbl[1] = '{0, 0, 10'h010, 64'd0, 8'h00, 64'hDEADBEEF_CAFEF00D, 0};
    tbl[2] = '{0, 1, 10'h010, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'd0, 0};
    tbl[3] = '{0, 0, 10'h010, 64'd0, 8'h00, 64'hDEADBEEF_FFFFFFFF, 0};
    tbl[4] = '{1, 1, 10'h030, 64'd0, 8'hFF, 64'd0, 0};
    tbl[5] = '{0, 1, 10'h3E8, 64'h12345678_9ABCDEF0, 8'hFF, 64'd0, 1};
    tbl[6] = '{1, 0, 10'h3FF, 64'd0, 8'h00, 64'd0, 1};
    tbl[7] = '{0, 0, 10'h3E8, 64'd0, 8'h00, 64'd0, 1};
    tbl[8] = '{1, 1, 10'h010, 64'd0, 8'h00, 64'd0, 0};
    tbl[9] = '{1, 0, 10'h010, 64'd0, 8'h00, 64'hDEADBEEF_FFFFFFFF, 0};
    pool = '{10'h005, 10'h006, 10'h007, 10'h3E6, 10'h3E7, 10'h3E8, 10'h3FF};

    m_has = '0; m_wpend = '0; m_acc = '0; m_live = 1'b0; m_eerr = '0;
    for (int p = 0; p < NP; p++) m_edata[p] = '0;
    idle();
    aresetn = 1'b0;
    @(posedge aclk); #1;
    cycle(); cycle();
    aresetn = 1'b1;

    // Directed single-port table
    for (int i = 0; i < 10; i++)
      do_op(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].strb,
            tbl[i].exp_d, tbl[i].exp_e, $sformatf("vec%0d", i));

    // Collision: both write 0x020; port 0 wins, then port 1. Port 0 reads
    // the address while port 1's write lands, proving port 0 landed first.
    idle();
    v = 2'b11; we_d = 2'b11; a_d[0] = 10'h020; a_d[1] = 10'h020;
    d_d[0] = {16{4'h1}}; d_d[1] = {16{4'h2}}; s_d[0] = 8'hFF; s_d[1] = 8'hFF;
    cycle();
    chk("col_p0_ready", 64'(s_rdy[0]), 64'd1);
    chk("col_p1_stall", 64'(s_rdy[1]), 64'd0);
    we_d[0] = 1'b0;
    cycle();
    chk("col_p1_ready", 64'(s_rdy[1]), 64'd1);
    chk("col_p0_rd_ready", 64'(s_rdy[0]), 64'd1);
    v = 2'b00;
    cycle();
    chk("col_p0_first", s_rdata[0], {16{4'h1}});
    do_op(0, 0, 10'h020, 64'd0, 8'h00, {16{4'h2}}, 0, "col_final");

    // Read-first: port 1 writes 0x030 while port 0 reads it (port 0 is the
    // lower index, so the read is not held off by the write).
    idle();
    v = 2'b11; we_d = 2'b10; a_d[0] = 10'h030; a_d[1] = 10'h030;
    d_d[1] = {32{2'b10}} ^ 64'h0F0F0F0F_0F0F0F0F; s_d[1] = 8'hFF;
    cycle();
    chk("rf_ready", 64'(s_rdy), 64'd3);
    v = 2'b00;
    cycle();
    chk("rf_rvalid", 64'(s_rvalid[0]), 64'd1);
    chk("rf_old", s_rdata[0], 64'd0);
    do_op(0, 0, 10'h030, 64'd0, 8'h00, 64'hA5A5A5A5_A5A5A5A5, 0, "rf_new");

    // Back-pressure on port 1: three reads, response held while stalled.
    idle();
    rr[1] = 1'b0; v[1] = 1'b1; a_d[1] = 10'h010;
    cycle();
    chk("bp_acc1", 64'(s_rdy[1]), 64'd1);
    a_d[1] = 10'h020;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_stall", 64'(s_rdy[1]), 64'd0);
      chk("bp_hold_valid", 64'(s_rvalid[1]), 64'd1);
      chk("bp_hold_data", s_rdata[1], 64'hDEADBEEF_FFFFFFFF);
    end
    rr[1] = 1'b1;
    cycle();
    chk("bp_acc2", 64'(s_rdy[1]), 64'd1);
    chk("bp_data1", s_rdata[1], 64'hDEADBEEF_FFFFFFFF);
    a_d[1] = 10'h030;
    cycle();
    chk("bp_acc3", 64'(s_rdy[1]), 64'd1);
    chk("bp_cont2", 64'(s_rvalid[1]), 64'd1);
    chk("bp_data2", s_rdata[1], {16{4'h2}});
    v[1] = 1'b0;
    cycle();
    chk("bp_cont3", 64'(s_rvalid[1]), 64'd1);
    chk("bp_data3", s_rdata[1], 64'hA5A5A5A5_A5A5A5A5);
    cycle();
    chk("bp_drained", 64'(s_rvalid[1]), 64'd0);

    // Reset with a response pending: rsp_valid must drop immediately.
    idle();
    rr[0] = 1'b0; v[0] = 1'b1; a_d[0] = 10'h010;
    cycle();
    v[0] = 1'b0;
    cycle();
    chk("pend_valid", 64'(s_rvalid[0]), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("arst_rvalid", 64'(rsp_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_rdata", rsp_rdata[63:0], 64'd0);
    @(posedge aclk); #1;
    idle();
    cycle(); cycle();
    aresetn = 1'b1;

    // Initialise the in-range random address pool.
    for (int i = 0; i < 7; i++)
      if (int'(pool[i]) < DP)
        do_op(i % 2, 1, pool[i], {$urandom, $urandom}, 8'hFF, 64'd0, 0, "init");

    // Randomized traffic; each port holds its request until accepted.
    idle();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p] = 1'b1;
          we_d[p] = 1'($urandom_range(0, 1));
          a_d[p]  = pool[$urandom_range(0, 6)];
          d_d[p]  = {$urandom, $urandom};
          s_d[p]  = 8'($urandom);
        end
        rr[p] = ($urandom_range(0, 3) != 0);
      end
      v = pend;
      cycle();
      pend = pend & ~m_acc;
    end
    v = '0; rr = '1;
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
